// File: rtl/mdr_pkg.sv
// Shared definitions for the memory data register (MDR) nibble paths.
// The load path and the write-back path both use these.
// Holds the data geometry, the write-back FSM state encoding and the one-hot
// nibble-enable constants. Decode helpers map a write state to its nibble
// index and its enable.
package mdr_pkg;

  localparam int NIB_W   = 4;
  localparam int WORD_W  = 16;
  localparam int NIB_CNT = 4;

  // The nibble enables are one-hot, MS nibble first. They match the load path.
  localparam logic [NIB_CNT-1:0] EN_N3   = 4'b1000;
  localparam logic [NIB_CNT-1:0] EN_N2   = 4'b0100;
  localparam logic [NIB_CNT-1:0] EN_N1   = 4'b0010;
  localparam logic [NIB_CNT-1:0] EN_N0   = 4'b0001;
  localparam logic [NIB_CNT-1:0] EN_NONE = 4'b0000;

  // The write-back sequence walks W3 -> W0, which is MS nibble first.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_W3   = 3'd1,
    S_W2   = 3'd2,
    S_W1   = 3'd3,
    S_W0   = 3'd4
  } state_t;

  // Nibble index within the word for a write state. Index 0 is the MS nibble.
  function automatic logic [1:0] idx_of(input state_t s);
    logic [1:0] idx;
    idx = 2'b00;
    case (s)
      S_W3:    idx = 2'b00;
      S_W2:    idx = 2'b01;
      S_W1:    idx = 2'b10;
      S_W0:    idx = 2'b11;
      default: idx = 2'b00;
    endcase
    return idx;
  endfunction

  // One-hot nibble enable for a write state. It is all zeros outside a write.
  function automatic logic [NIB_CNT-1:0] nib_en_of(input state_t s);
    logic [NIB_CNT-1:0] en;
    en = EN_NONE;
    case (s)
      S_W3:    en = EN_N3;
      S_W2:    en = EN_N2;
      S_W1:    en = EN_N1;
      S_W0:    en = EN_N0;
      default: en = EN_NONE;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/mdr_nibble_mux.sv
// Combinational 16->4 nibble select.
// idx 0 selects the MS nibble [15:12] and idx 3 selects the LS nibble [3:0].
// The debug read port reuses this block, so it carries no state.
module mdr_nibble_mux
  import mdr_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [1:0]        idx,
  output logic [NIB_W-1:0]  nib
);

  // Select the nibble; index order runs from the MS end of the word.
  always_comb begin
    nib = '0;
    case (idx)
      2'b00: nib = word[15:12];
      2'b01: nib = word[11:8];
      2'b10: nib = word[7:4];
      2'b11: nib = word[3:0];
      default: nib = '0;
    endcase
  end

endmodule

// File: rtl/mdr_nibble_writer.sv
// MDR write-back path: writes one 16-bit word to the 4-bit data memory as
// four nibble writes, MS nibble first, at nibble address {word_addr, idx}.
//
// Handshake: a word transfers on a rising clk edge where in_valid and
// in_ready are both high. in_ready is high only in IDLE. The word and
// address are captured at that edge, so later input changes are ignored.
// The source must hold in_valid until it sees in_ready. Nothing is queued
// while busy.
//
// Optional feature, macro MDR_WR_STALL_EN: adds a mem_ready input.
// Each write state then advances only on mem_ready = 1, and the write
// outputs hold steady while the memory stalls. Without the macro the
// memory takes one nibble every cycle.
//
// state_dbg exposes the FSM state encoding (mdr_pkg::state_t) for observation.
module mdr_nibble_writer
  import mdr_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_word,
  input  logic [ADDR_W-1:0] in_addr,
`ifdef MDR_WR_STALL_EN
  input  logic              mem_ready,
`endif
  output logic              mem_we,
  output logic [ADDR_W+1:0] mem_addr,
  output logic [3:0]        mem_wdata,
  output logic [3:0]        nib_en,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state_dbg
);

  state_t              state;
  logic [WORD_W-1:0]   word_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [1:0]          idx;
  logic [NIB_W-1:0]    nib_sel;
  logic                adv;
  logic                accept;

`ifdef MDR_WR_STALL_EN
  // The memory may stall a write; the write state holds until it is taken.
  assign adv = mem_ready;
`else
  // The memory accepts a nibble every cycle.
  assign adv = 1'b1;
`endif

  assign accept = in_valid && (state == S_IDLE);

  // FSM and capture registers. The reset is asynchronous, so an
  // in-flight sequence is abandoned at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      word_q <= '0;
      addr_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            word_q <= in_word;
            addr_q <= in_addr;
            state  <= S_W3;
          end
        end
        S_W3:    if (adv) state <= S_W2;
        S_W2:    if (adv) state <= S_W1;
        S_W1:    if (adv) state <= S_W0;
        S_W0:    if (adv) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // The nibble data comes from the captured word, never from the live input.
  mdr_nibble_mux u_nib_mux (
    .word (word_q),
    .idx  (idx),
    .nib  (nib_sel)
  );

  // Decode the outputs from the registered state. Address and data are
  // zeroed outside a write, so an idle bus shows the reset values.
  always_comb begin
    idx       = idx_of(state);
    nib_en    = nib_en_of(state);
    in_ready  = (state == S_IDLE);
    busy      = (state != S_IDLE);
    mem_we    = (state != S_IDLE);
    done      = (state == S_W0) && adv;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state != S_IDLE) begin
      mem_addr  = {addr_q, idx};
      mem_wdata = nib_sel;
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_mdr_nibble_writer.sv
// Directed bench for mdr_nibble_writer in the default build (no stall input).
// A behavioural nibble memory records every strobed write so whole words can
// be read back. All expected values are hand-computed constants.
module tb_mdr_nibble_writer;
  import mdr_pkg::*;

  logic        clk;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_word;
  logic [7:0]  in_addr;
  logic        mem_we;
  logic [9:0]  mem_addr;
  logic [3:0]  mem_wdata;
  logic [3:0]  nib_en;
  logic        busy;
  logic        done;
  logic [2:0]  state_dbg;

  int n_cmp = 0;
  int n_err = 0;
  int wr_count = 0;
  int c0;

  logic [3:0] mem_model [0:1023] = '{default: 4'h0};

  mdr_nibble_writer #(.ADDR_W(8)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_word   (in_word),
    .in_addr   (in_addr),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .nib_en    (nib_en),
    .busy      (busy),
    .done      (done),
    .state_dbg (state_dbg)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: a write commits at the rising edge that ends a strobed cycle.
  always @(posedge clk) begin
    if (mem_we) begin
      mem_model[mem_addr] <= mem_wdata;
      wr_count <= wr_count + 1;
    end
  end

  function automatic logic [15:0] rd_word(input logic [7:0] a);
    return {mem_model[{a, 2'b00}], mem_model[{a, 2'b01}],
            mem_model[{a, 2'b10}], mem_model[{a, 2'b11}]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // A write cycle: strobe, address, data, enable, done, plus handshake state.
  task automatic exp_wr(input string tag, input logic [9:0] a, input logic [3:0] d,
                        input logic [3:0] en, input logic dn);
    chk({tag, ".we"},    {31'd0, mem_we}, 32'd1);
    chk({tag, ".addr"},  {22'd0, mem_addr}, {22'd0, a});
    chk({tag, ".wdata"}, {28'd0, mem_wdata}, {28'd0, d});
    chk({tag, ".nib_en"},{28'd0, nib_en}, {28'd0, en});
    chk({tag, ".done"},  {31'd0, done}, {31'd0, dn});
    chk({tag, ".ready"}, {31'd0, in_ready}, 32'd0);
    chk({tag, ".busy"},  {31'd0, busy}, 32'd1);
  endtask

  // Idle / reset values on every output.
  task automatic exp_idle(input string tag);
    chk({tag, ".we"},     {31'd0, mem_we}, 32'd0);
    chk({tag, ".addr"},   {22'd0, mem_addr}, 32'd0);
    chk({tag, ".wdata"},  {28'd0, mem_wdata}, 32'd0);
    chk({tag, ".nib_en"}, {28'd0, nib_en}, 32'd0);
    chk({tag, ".done"},   {31'd0, done}, 32'd0);
    chk({tag, ".ready"},  {31'd0, in_ready}, 32'd1);
    chk({tag, ".busy"},   {31'd0, busy}, 32'd0);
    chk({tag, ".state"},  {29'd0, state_dbg}, {29'd0, S_IDLE});
  endtask

  initial begin
    reset_n  = 1'b0;
    in_valid = 1'b0;
    in_word  = 16'h0;
    in_addr  = 8'h0;

    // Reset values while reset is held
    repeat (2) @(posedge clk);
    #1;
    exp_idle("reset");
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    exp_idle("post_reset");

    // 1: single word A5C3 @10, valid for one cycle only
    in_valid = 1'b1; in_word = 16'hA5C3; in_addr = 8'h10;
    tick();
    in_valid = 1'b0;
    exp_wr("t1.w3", 10'h040, 4'hA, 4'b1000, 1'b0);
    tick(); exp_wr("t1.w2", 10'h041, 4'h5, 4'b0100, 1'b0);
    tick(); exp_wr("t1.w1", 10'h042, 4'hC, 4'b0010, 1'b0);
    tick(); exp_wr("t1.w0", 10'h043, 4'h3, 4'b0001, 1'b1);
    tick(); exp_idle("t1.end");
    chk("t1.readback", {16'd0, rd_word(8'h10)}, 32'h0000A5C3);

    // 2: back-to-back words, in_valid held across the first sequence
    in_valid = 1'b1; in_word = 16'h1234; in_addr = 8'h00;
    tick();
    in_word = 16'hFFFF; in_addr = 8'h01;
    exp_wr("t2a.w3", 10'h000, 4'h1, 4'b1000, 1'b0);
    tick(); exp_wr("t2a.w2", 10'h001, 4'h2, 4'b0100, 1'b0);
    tick(); exp_wr("t2a.w1", 10'h002, 4'h3, 4'b0010, 1'b0);
    tick(); exp_wr("t2a.w0", 10'h003, 4'h4, 4'b0001, 1'b1);
    tick(); exp_idle("t2.gap");
    tick();
    in_valid = 1'b0;
    exp_wr("t2b.w3", 10'h004, 4'hF, 4'b1000, 1'b0);
    tick(); exp_wr("t2b.w2", 10'h005, 4'hF, 4'b0100, 1'b0);
    tick(); exp_wr("t2b.w1", 10'h006, 4'hF, 4'b0010, 1'b0);
    tick(); exp_wr("t2b.w0", 10'h007, 4'hF, 4'b0001, 1'b1);
    tick(); exp_idle("t2.end");
    chk("t2.readback0", {16'd0, rd_word(8'h00)}, 32'h00001234);
    chk("t2.readback1", {16'd0, rd_word(8'h01)}, 32'h0000FFFF);

    // 3: input activity during busy must not disturb the captured word
    in_valid = 1'b1; in_word = 16'h5A69; in_addr = 8'h20;
    tick();
    in_valid = 1'b0; in_word = 16'hDEAD; in_addr = 8'h77;
    exp_wr("t3.w3", 10'h080, 4'h5, 4'b1000, 1'b0);
    tick();
    in_valid = 1'b1; in_word = 16'hBEEF; in_addr = 8'h78;
    exp_wr("t3.w2", 10'h081, 4'hA, 4'b0100, 1'b0);
    tick();
    in_valid = 1'b0; in_word = 16'h0000;
    exp_wr("t3.w1", 10'h082, 4'h6, 4'b0010, 1'b0);
    tick();
    in_valid = 1'b1; in_word = 16'hFFFF;
    exp_wr("t3.w0", 10'h083, 4'h9, 4'b0001, 1'b1);
    in_valid = 1'b0;
    tick(); exp_idle("t3.end");
    tick(); exp_idle("t3.stay_idle");
    chk("t3.readback", {16'd0, rd_word(8'h20)}, 32'h00005A69);
    chk("t3.no_stray", {16'd0, rd_word(8'h78)}, 32'h00000000);

    // 4: reset lands right after W2's write commits -> only B and E written
    c0 = wr_count;
    in_valid = 1'b1; in_word = 16'hBEEF; in_addr = 8'h30;
    tick();
    in_valid = 1'b0;
    exp_wr("t4.w3", 10'h0C0, 4'hB, 4'b1000, 1'b0);
    tick(); exp_wr("t4.w2", 10'h0C1, 4'hE, 4'b0100, 1'b0);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    exp_idle("t4.abort");
    @(posedge clk);
    #1;
    exp_idle("t4.in_reset");
    @(negedge clk);
    reset_n = 1'b1;
    chk("t4.wr_count", wr_count - c0, 32'd2);
    chk("t4.nib0", {28'd0, mem_model[10'h0C0]}, 32'hB);
    chk("t4.nib1", {28'd0, mem_model[10'h0C1]}, 32'hE);
    chk("t4.nib2", {28'd0, mem_model[10'h0C2]}, 32'h0);
    chk("t4.nib3", {28'd0, mem_model[10'h0C3]}, 32'h0);
    tick();
    in_valid = 1'b1; in_word = 16'h1357; in_addr = 8'h31;
    tick();
    in_valid = 1'b0;
    exp_wr("t4n.w3", 10'h0C4, 4'h1, 4'b1000, 1'b0);
    tick(); exp_wr("t4n.w2", 10'h0C5, 4'h3, 4'b0100, 1'b0);
    tick(); exp_wr("t4n.w1", 10'h0C6, 4'h5, 4'b0010, 1'b0);
    tick(); exp_wr("t4n.w0", 10'h0C7, 4'h7, 4'b0001, 1'b1);
    tick(); exp_idle("t4n.end");
    chk("t4n.readback", {16'd0, rd_word(8'h31)}, 32'h00001357);

    // 5: top word address, nibble addresses reach all-ones without wrapping
    in_valid = 1'b1; in_word = 16'h0F0F; in_addr = 8'hFF;
    tick();
    in_valid = 1'b0;
    exp_wr("t5.w3", 10'h3FC, 4'h0, 4'b1000, 1'b0);
    tick(); exp_wr("t5.w2", 10'h3FD, 4'hF, 4'b0100, 1'b0);
    tick(); exp_wr("t5.w1", 10'h3FE, 4'h0, 4'b0010, 1'b0);
    tick(); exp_wr("t5.w0", 10'h3FF, 4'hF, 4'b0001, 1'b1);
    tick(); exp_idle("t5.end");
    chk("t5.readback", {16'd0, rd_word(8'hFF)}, 32'h00000F0F);
    chk("t5.no_wrap", {16'd0, rd_word(8'h00)}, 32'h00001234);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
